mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arb_rr.sv | 19 +
 rtl/mem_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the two-port block-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I-cache/D-cache block ports, the arbiter and the shared memory.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              m0_valid;
  logic              m0_rw;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_din;
  logic [DATA_W-1:0] m0_dout;
  logic              m0_ready;

  logic              m1_valid;
  logic              m1_rw;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_din;
  logic [DATA_W-1:0] m1_dout;
  logic              m1_ready;

  logic              mem_valid;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_ready;

  // slave: the arbiter's view; master: the requesters plus the memory
  modport slave (
    input  m0_valid, m0_rw, m0_addr, m0_din,
    output m0_dout, m0_ready,
    input  m1_valid, m1_rw, m1_addr, m1_din,
    output m1_dout, m1_ready,
    output mem_valid, mem_rw, mem_addr, mem_din,
    input  mem_dout, mem_ready
  );

  modport master (
    output m0_valid, m0_rw, m0_addr, m0_din,
    input  m0_dout, m0_ready,
    output m1_valid, m1_rw, m1_addr, m1_din,
    input  m1_dout, m1_ready,
    input  mem_valid, mem_rw, mem_addr, mem_din,
    output mem_dout, mem_ready
  );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the one not granted last.
module mem_arb_rr (
  input  logic v0_i,
  input  logic v1_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic any_valid_o
);

  always_comb begin
    any_valid_o = v0_i | v1_i;
    if (v0_i && v1_i) begin
      grant_o = ~last_grant_i;
    end else begin
      grant_o = v1_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache (m0) and D-cache (m1) block ports onto one shared block memory,
// one transfer at a time, with a quiet RELEASE cycle between transfers.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic         cpu_clk,
  input  logic         cpu_rst,
  mem_arbiter_if.slave bus,
  output logic [31:0]  conflict_cnt,
  output logic [31:0]  grant0_cnt,
  output logic [31:0]  grant1_cnt
);

  arb_state_e        state_q;
  logic              owner_q;
  logic              last_grant_q;
  logic              mem_valid_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [31:0]       conflict_q;
  logic [31:0]       grant0_q;
  logic [31:0]       grant1_q;

  logic grant;
  logic any_valid;
  logic done;
  logic rdy0;
  logic rdy1;

  mem_arb_rr u_rr (
    .v0_i         (bus.m0_valid),
    .v1_i         (bus.m1_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .any_valid_o  (any_valid)
  );

  // Ready is combinational on mem_ready so the owner sees it in the same cycle.
  assign done = (state_q == BUSY) && bus.mem_ready;
  assign rdy0 = done && !owner_q;
  assign rdy1 = done &&  owner_q;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_valid_q  <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      conflict_q   <= '0;
      grant0_q     <= '0;
      grant1_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.m0_valid && bus.m1_valid) begin
            conflict_q <= conflict_q + 32'd1;
          end
          if (any_valid) begin
            owner_q      <= grant;
            last_grant_q <= grant;
            rw_q         <= grant ? bus.m1_rw   : bus.m0_rw;
            addr_q       <= grant ? bus.m1_addr : bus.m0_addr;
            din_q        <= grant ? bus.m1_din  : bus.m0_din;
            mem_valid_q  <= 1'b1;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            if (owner_q) begin
              grant1_q <= grant1_q + 32'd1;
            end else begin
              grant0_q <= grant0_q + 32'd1;
            end
            mem_valid_q <= 1'b0;
            state_q     <= RELEASE;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_rw    = rw_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = din_q;

  assign bus.m0_ready  = rdy0;
  assign bus.m1_ready  = rdy1;
  assign bus.m0_dout   = rdy0 ? bus.mem_dout : '0;
  assign bus.m1_dout   = rdy1 ? bus.mem_dout : '0;

  assign conflict_cnt  = conflict_q;
  assign grant0_cnt    = grant0_q;
  assign grant1_cnt    = grant1_q;

endmodule
